// File: rtl/regfile_scoreboard.sv
// Integer register file: NRD read ports, 1 write port, per-register busy
// scoreboard, optional write-through bypass, and a multi-cycle clear sweep.
// Ports: clk, rst (sync, active-low), clr_req, ready,
//   rd_addr/rd_data/rd_busy (NRD ports, combinational reads),
//   iss_valid/iss_rd (mark busy), wb_valid/wb_rd/wb_data (retire).
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writebacks.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data
);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    idx_nx;

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;

  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [XLEN-1:0]  mem_wd;
  logic             wb_go;
  logic             iss_go;
  logic             busy_clr;
  logic [AW-1:0]    ra;

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    mem_we   = 1'b0;
    mem_wa   = '0;
    mem_wd   = '0;
    wb_go    = 1'b0;
    iss_go   = 1'b0;
    busy_clr = 1'b0;
    unique case (state)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = idx;
        idx_nx = idx + AW'(1);
        if (idx == AW'(NREGS - 1)) begin
          state_nx = IDLE;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
          idx_nx   = '0;
          busy_clr = 1'b1;
        end else begin
          wb_go  = wb_valid && (wb_rd != '0);
          iss_go = iss_valid && (iss_rd != '0);
          mem_we = wb_go;
          mem_wa = wb_rd;
          mem_wd = wb_data;
        end
      end
      default: begin
        state_nx = CLEAR;
        idx_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Issue is applied after writeback so a same-cycle producer stays busy.
  always_ff @(posedge clk) begin
    if (!rst || busy_clr) begin
      busy <= '0;
    end else begin
      if (wb_go) begin
        busy[wb_rd] <= 1'b0;
      end
      if (iss_go) begin
        busy[iss_rd] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int p = 0; p < NRD; p++) begin
      ra = rd_addr[p*AW +: AW];
      if (ready && (ra != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && (wb_rd == ra)) begin
          rd_data[p*XLEN +: XLEN] = wb_data;
          rd_busy[p]              = 1'b0;
        end else begin
          rd_data[p*XLEN +: XLEN] = mem[ra];
          rd_busy[p]              = busy[ra];
        end
`else
        rd_data[p*XLEN +: XLEN] = mem[ra];
        rd_busy[p]              = busy[ra];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios with
// literal expectations plus randomized traffic against a reference model.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                clr_req;
  logic                ready;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)
  ) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: contents, busy flags, and cycles left until ready.
  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_busy [NREGS];
  int              cnt = 0;
  bit              m_init = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < NREGS; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    cnt = NREGS;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_init = 1'b1;
      model_zero();
    end else if (!m_init) begin
      cnt = cnt;
    end else if (cnt > 0) begin
      cnt--;
    end else if (clr_req) begin
      model_zero();
    end else begin
      if (wb_valid && wb_rd != 0) begin
        m_mem[wb_rd]  = wb_data;
        m_busy[wb_rd] = 1'b0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  end

  function automatic logic [AW-1:0] port_addr(input int p);
    return rd_addr[p*AW +: AW];
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int p);
    logic [AW-1:0] a;
    a = port_addr(p);
    if (cnt != 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && wb_rd == a) return wb_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int p);
    logic [AW-1:0] a;
    a = port_addr(p);
    if (cnt != 0 || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && wb_rd == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_ready", {63'd0, ready}, {63'd0, cnt == 0});
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("m_data%0d", p), {32'd0, rd_data[p*XLEN +: XLEN]},
            {32'd0, exp_data(p)});
        chk($sformatf("m_busy%0d", p), {63'd0, rd_busy[p]},
            {63'd0, exp_busy(p)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ready && n < 200);
  endtask

  task automatic idle_in();
    clr_req   = 1'b0;
    iss_valid = 1'b0;
    wb_valid  = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] d0();
    return rd_data[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] d1();
    return rd_data[2*XLEN-1:XLEN];
  endfunction

  int n;

  initial begin
    rst = 1'b0;
    idle_in();
    iss_rd  = '0;
    wb_rd   = '0;
    wb_data = '0;
    rd_addr = '0;

    // Reset and first sweep
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, ready}, 64'd0);
    rst = 1'b1;
    wait_ready(n);
    chk("rst_lat", n, 64'd32);
    set_addr(0, 5'd3);
    set_addr(1, 5'd31);
    #1;
    chk("rst_rd0", d0(), 64'd0);
    chk("rst_rd1", d1(), 64'd0);

    // Write then read
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    step();
    wb_valid = 1'b0;
    set_addr(0, 5'd5);
    #1;
    chk("wr_data", d0(), 64'hDEADBEEF);
    chk("wr_busy", {63'd0, rd_busy[0]}, 64'd0);

    // Write to x0 is discarded
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    step();
    wb_valid = 1'b0;
    set_addr(0, 5'd0);
    #1;
    chk("x0_data", d0(), 64'd0);

    // Scoreboard busy and bypass
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    set_addr(1, 5'd7);
    #1;
    chk("sb_busy", {63'd0, rd_busy[1]}, 64'd1);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", d1(), 64'h55);
    chk("byp_busy", {63'd0, rd_busy[1]}, 64'd0);
`else
    chk("nbyp_data", d1(), 64'h0);
    chk("nbyp_busy", {63'd0, rd_busy[1]}, 64'd1);
`endif
    step();
    wb_valid = 1'b0;
    #1;
    chk("sb_data", d1(), 64'h55);
    chk("sb_clr", {63'd0, rd_busy[1]}, 64'd0);

    // Issue and writeback collide
    iss_valid = 1'b1; iss_rd = 5'd9;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hA5;
    step();
    idle_in();
    set_addr(0, 5'd9);
    #1;
    chk("col_data", d0(), 64'hA5);
    chk("col_busy", {63'd0, rd_busy[0]}, 64'd1);

    // Fill, then clear with a same-cycle writeback that must drop
    for (int i = 1; i < NREGS; i++) begin
      wb_valid = 1'b1; wb_rd = AW'(i); wb_data = 32'h01010101 * i;
      step();
    end
    wb_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd12;
    step();
    clr_req = 1'b1;
    iss_rd = 5'd4;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hFFFF;
    step();
    idle_in();
    chk("clr_ready", {63'd0, ready}, 64'd0);
    wait_ready(n);
    chk("clr_lat", n, 64'd32);
    set_addr(0, 5'd3);
    set_addr(1, 5'd12);
    #1;
    chk("clr_d3", d0(), 64'd0);
    chk("clr_d12", d1(), 64'd0);
    chk("clr_b12", {63'd0, rd_busy[1]}, 64'd0);
    set_addr(1, 5'd4);
    #1;
    chk("clr_b4", {63'd0, rd_busy[1]}, 64'd0);

    // Reset in the middle of a sweep restarts it
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    wait_ready(n);
    chk("midrst_lat", n, 64'd32);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7))
                                              : AW'($urandom);
      wb_valid  = ($urandom_range(0, 1) == 0);
      wb_rd     = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7))
                                              : AW'($urandom);
      wb_data   = $urandom;
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 3) == 0) set_addr(p, wb_rd);
        else if ($urandom_range(0, 2) == 0) set_addr(p, iss_rd);
        else set_addr(p, AW'($urandom));
      end
      clr_req = ($urandom_range(0, 299) == 0);
      rst     = !($urandom_range(0, 699) == 0);
      step();
    end

    idle_in();
    rst = 1'b1;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
